trdb_qual_sync: RTL and testbench
=================================

# trdb_qual_sync

Sequential consumer of the per-instruction trace-qualification signal produced by the filtering logic. It tracks qualified and unqualified spans of retired instructions and turns their boundaries into packet requests. Those requests go to the packet emitter: START, STOP and periodic RESYNC. They are buffered in a small FIFO behind a valid/ready handshake. The block sits between the filter and the packet generator in the trace debugger pipeline.

## Interface
Parameters:
- `FIFO_DEPTH`, default 2: request buffer entries; must be a power of two and at least 2.
- `XLEN` comes from `trdb_pkg`.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_ni`, in, 1: reset, asynchronous and active-low.
- `ivalid_i`, in, 1: an instruction retires this cycle.
- `iaddr_i`, in, XLEN: address of the retired instruction.
- `trace_qualified_i`, in, 1: filter verdict for `iaddr_i`; only meaningful when `ivalid_i` is high.
- `flush_i`, in, 1: force the end of an active trace span.
- `resync_max_i`, in, 16: resync period, counted in qualified instructions; 0 disables resync.
- `req_valid_o`, out, 1: a request is available.
- `req_ready_i`, in, 1: the emitter accepts the request.
- `req_kind_o`, out, 2: request kind; 0 = START, 1 = STOP, 2 = RESYNC, 3 is unused.
- `req_addr_o`, out, XLEN: address carried by the request.
- `active_o`, out, 1: high while the block is in the TRACING state.
- `lost_o`, out, 1: one-cycle pulse when a request was dropped.

## Operation
State machine with two states, IDLE and TRACING. Reset enters IDLE.

IDLE:
- On `ivalid_i` and `trace_qualified_i`:
  - push START carrying `iaddr_i`;
  - latch `iaddr_i` as last_addr;
  - clear the counter;
  - go to TRACING.
- `flush_i` is ignored in IDLE.

TRACING, evaluated in this priority order:
1. `flush_i`: push STOP carrying last_addr and go to IDLE. Any `ivalid_i` in the same cycle is neither counted nor latched.
2. `ivalid_i` and not `trace_qualified_i`: push STOP carrying last_addr, where last_addr is the address of the last qualified instruction. Go to IDLE.
3. `ivalid_i` and `trace_qualified_i`:
   - latch `iaddr_i` as last_addr;
   - if `resync_max_i` is non-zero and counter+1 is at least `resync_max_i`, push RESYNC carrying `iaddr_i` and clear the counter;
   - otherwise increment the counter.
4. No `ivalid_i`: hold state and counter.

Counter rules:
- The counter is 16 bits unsigned.
- The comparison uses "at least" so that lowering `resync_max_i` mid-span triggers RESYNC on the next qualified instruction rather than requiring a wrap.

FIFO rules:
- At most one push per cycle.
- Pop happens when `req_valid_o` and `req_ready_i` are both high.
- Push while full and a pop happens the same cycle: the push is accepted and the FIFO stays full.
- Push while full and no pop: the request is dropped. The state machine still transitions. `lost_o` pulses high in the next cycle.
- Pointers wrap modulo `FIFO_DEPTH`. An extra wrap bit distinguishes full from empty.

## Timing
Reset values:
- `req_valid_o` 0, `req_kind_o` 0, `req_addr_o` 0, `active_o` 0, `lost_o` 0.
- FIFO empty, counter 0, last_addr 0.

Latency:
- A push in cycle N makes the request visible at the FIFO head, with `req_valid_o` high, in cycle N+1 if the FIFO was empty.
- `active_o` changes in the cycle after the triggering event.

Handshake:
- `req_kind_o` and `req_addr_o` are stable while `req_valid_o` is high and `req_ready_i` is low.
- `req_valid_o` does not depend combinationally on `req_ready_i`.
- Outputs are driven from registers or the FIFO head; there is no combinational path from `ivalid_i` to the outputs.

Back-to-back events:
- START and STOP in consecutive cycles occupy two entries; nothing is merged.

Reset mid-operation:
- Asynchronously clears the FIFO, counter and state.
- Requests still pending are discarded and `lost_o` is not pulsed.

## Configuration
Macro `TRDB_RESYNC_EN`.

Defined:
- The resync counter and RESYNC generation are present as described above.

Undefined:
- The counter logic is removed and `resync_max_i` is ignored.
- RESYNC is never emitted.
- TRACING changes only on flush or on an unqualified instruction.

## Test plan
- Reset, then qualified `ivalid_i` at 0x100, with `req_ready_i` held high: one START/0x100 in the next cycle, then `active_o` = 1.
- Qualified 0x100, 0x104, 0x108, then unqualified 0x200: START/0x100 followed by STOP/0x108, and `active_o` returns to 0.
- `resync_max_i` = 3, seven consecutive qualified instructions 0x0, 0x4, …, 0x18: START/0x0, RESYNC/0xC, RESYNC/0x18. With the macro undefined, only START/0x0.
- `req_ready_i` held low, `FIFO_DEPTH` = 2, three events START, STOP, START: the first two are held stable at the head, the third is dropped, `lost_o` pulses once, and `active_o` = 1.
- `flush_i` together with qualified `ivalid_i` 0x300 while tracing with last_addr 0x2FC: STOP/0x2FC, IDLE, and 0x300 is not latched.
- `rst_ni` asserted with 2 entries pending: `req_valid_o` = 0 immediately, and the next qualified instruction produces a fresh START.

Source files
------------

// File: rtl/trdb_qual_sync.sv
// rtl/trdb_qual_sync.sv - trace qualification span tracker emitting START/STOP/RESYNC requests
// Optional feature: define TRDB_RESYNC_EN to build the periodic RESYNC counter.

package trdb_pkg;
    parameter int XLEN = 32;

    typedef enum logic [1:0] {
        REQ_START  = 2'd0,
        REQ_STOP   = 2'd1,
        REQ_RESYNC = 2'd2
    } req_kind_e;
endpackage

module trdb_req_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 34
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         full_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wptr_q, wptr_d;
    logic [PTR_W:0] rptr_q, rptr_d;
    logic [W-1:0]   mem_q [DEPTH];
    logic           empty;
    logic           push_ok;
    logic           pop_ok;

    assign empty   = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                     (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign valid_o = !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign data_o  = empty ? '0 : mem_q[rptr_q[PTR_W-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (push_ok) mem_q[wptr_q[PTR_W-1:0]] <= data_i;
        end
    end
endmodule

module trdb_qual_sync
    import trdb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ivalid_i,
    input  logic [XLEN-1:0] iaddr_i,
    input  logic            trace_qualified_i,
    input  logic            flush_i,
    input  logic [15:0]     resync_max_i,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output logic [1:0]      req_kind_o,
    output logic [XLEN-1:0] req_addr_o,
    output logic            active_o,
    output logic            lost_o
);
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_TRACING = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] last_addr_q, last_addr_d;
    logic            lost_q, lost_d;

    logic            push;
    req_kind_e       push_kind;
    logic [XLEN-1:0] push_addr;
    logic            fifo_full;
    logic            fifo_valid;
    logic            pop;
    logic [XLEN+1:0] head;

`ifdef TRDB_RESYNC_EN
    logic [15:0] cnt_q, cnt_d;
    logic        resync_hit;

    // 17-bit compare so counter+1 never wraps before reaching the period.
    assign resync_hit = (resync_max_i != 16'd0) &&
                        (({1'b0, cnt_q} + 17'd1) >= {1'b0, resync_max_i});
`else
    logic unused_resync_max;
    assign unused_resync_max = ^resync_max_i;
`endif

    assign pop = fifo_valid && req_ready_i;

    always_comb begin
        state_d     = state_q;
        last_addr_d = last_addr_q;
        push        = 1'b0;
        push_kind   = REQ_START;
        push_addr   = '0;
`ifdef TRDB_RESYNC_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ivalid_i && trace_qualified_i) begin
                    push        = 1'b1;
                    push_kind   = REQ_START;
                    push_addr   = iaddr_i;
                    last_addr_d = iaddr_i;
                    state_d     = ST_TRACING;
`ifdef TRDB_RESYNC_EN
                    cnt_d       = '0;
`endif
                end
            end
            ST_TRACING: begin
                if (flush_i || (ivalid_i && !trace_qualified_i)) begin
                    push      = 1'b1;
                    push_kind = REQ_STOP;
                    push_addr = last_addr_q;
                    state_d   = ST_IDLE;
                end else if (ivalid_i) begin
                    last_addr_d = iaddr_i;
`ifdef TRDB_RESYNC_EN
                    if (resync_hit) begin
                        push      = 1'b1;
                        push_kind = REQ_RESYNC;
                        push_addr = iaddr_i;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The drop is judged against the FIFO state seen by this cycle's push.
    assign lost_d = push && fifo_full && !pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            last_addr_q <= '0;
            lost_q      <= 1'b0;
`ifdef TRDB_RESYNC_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_addr_q <= last_addr_d;
            lost_q      <= lost_d;
`ifdef TRDB_RESYNC_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    trdb_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (XLEN + 2)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  ({push_kind, push_addr}),
        .pop_i   (pop),
        .data_o  (head),
        .valid_o (fifo_valid),
        .full_o  (fifo_full)
    );

    assign req_valid_o = fifo_valid;
    assign req_kind_o  = head[XLEN+1:XLEN];
    assign req_addr_o  = head[XLEN-1:0];
    assign active_o    = (state_q == ST_TRACING);
    assign lost_o      = lost_q;
endmodule

// File: tb/tb_trdb_qual_sync.sv
// tb/tb_trdb_qual_sync.sv - scoreboard bench for trdb_qual_sync

module tb_trdb_qual_sync;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ivalid = 1'b0;
    logic [31:0] iaddr = '0;
    logic        qual = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] rmax = '0;
    logic        ready = 1'b1;
    logic        req_valid;
    logic [1:0]  req_kind;
    logic [31:0] req_addr;
    logic        active;
    logic        lost;

    trdb_qual_sync #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .ivalid_i          (ivalid),
        .iaddr_i           (iaddr),
        .trace_qualified_i (qual),
        .flush_i           (flush),
        .resync_max_i      (rmax),
        .req_valid_o       (req_valid),
        .req_ready_i       (ready),
        .req_kind_o        (req_kind),
        .req_addr_o        (req_addr),
        .active_o          (active),
        .lost_o            (lost)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    req_t expq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic m_active = 1'b0;
    logic [31:0] m_last = '0;
    int   m_cnt = 0;
    logic m_lost = 1'b0;
    int   lost_seen = 0;
    logic hold_chk = 1'b0;
    req_t held;
    req_t head_exp;
    req_t p;
    logic full_before;
    logic pop;
    logic do_push;

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            m_active = 1'b0;
            m_last   = '0;
            m_cnt    = 0;
            m_lost   = 1'b0;
            hold_chk = 1'b0;
            check("rst_valid", req_valid, 0);
            check("rst_kind", req_kind, 0);
            check("rst_addr", req_addr, 0);
            check("rst_active", active, 0);
            check("rst_lost", lost, 0);
        end else begin
            check("valid", req_valid, expq.size() != 0);
            check("active", active, m_active);
            check("lost", lost, m_lost);
            if (lost) lost_seen++;
            if (hold_chk && req_valid) check("hold", {req_kind, req_addr}, held);
            hold_chk = req_valid && !ready;
            held     = {req_kind, req_addr};

            full_before = (expq.size() == DEPTH);
            pop = req_valid && ready;
            if (pop) begin
                if (expq.size() == 0) begin
                    check("pop_unexpected", 1, 0);
                end else begin
                    head_exp = expq.pop_front();
                    check("kind", req_kind, head_exp.kind);
                    check("addr", req_addr, head_exp.addr);
                end
            end

            do_push = 1'b0;
            p = '0;
            if (!m_active) begin
                if (ivalid && qual) begin
                    do_push = 1'b1; p = {2'd0, iaddr};
                    m_last = iaddr; m_cnt = 0; m_active = 1'b1;
                end
            end else if (flush || (ivalid && !qual)) begin
                do_push = 1'b1; p = {2'd1, m_last};
                m_active = 1'b0;
            end else if (ivalid) begin
                m_last = iaddr;
`ifdef TRDB_RESYNC_EN
                if (rmax != 0 && m_cnt + 1 >= int'(rmax)) begin
                    do_push = 1'b1; p = {2'd2, iaddr};
                    m_cnt = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
`endif
            end
            m_lost = do_push && full_before && !pop;
            if (do_push && !m_lost) expq.push_back(p);
        end
    end

    task automatic instr(input logic v, input logic q, input logic [31:0] a, input logic f);
        @(posedge clk);
        #1;
        ivalid = v; qual = q; iaddr = a; flush = f;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) instr(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int lost_base;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // single START, then close the span
        instr(1, 1, 32'h100, 0);
        idle(3);
        instr(1, 0, 32'h104, 0);
        idle(3);

        // START/0x100 then STOP/0x108
        instr(1, 1, 32'h100, 0);
        instr(1, 1, 32'h104, 0);
        instr(1, 1, 32'h108, 0);
        instr(1, 0, 32'h200, 0);
        idle(3);

        // resync period 3 over seven qualified instructions
        rmax = 16'd3;
        for (int i = 0; i < 7; i++) instr(1, 1, 32'(i * 4), 0);
        instr(1, 0, 32'h40, 0);
        idle(3);
        rmax = 16'd0;

        // back-pressure: third request dropped
        ready = 1'b0;
        lost_base = lost_seen;
        instr(1, 1, 32'h10, 0);
        instr(1, 0, 32'h20, 0);
        instr(1, 1, 32'h30, 0);
        idle(4);
        check("lost_pulses", lost_seen - lost_base, 1);
        check("active_after_drop", active, 1);
        ready = 1'b1;
        idle(3);
        instr(1, 0, 32'h50, 0);
        idle(3);

        // flush beats a qualified instruction in the same cycle
        instr(1, 1, 32'h2FC, 0);
        instr(1, 1, 32'h300, 1);
        idle(3);
        check("active_after_flush", active, 0);
        instr(0, 0, 32'h0, 1);
        idle(3);

        // reset with two requests pending
        ready = 1'b0;
        instr(1, 1, 32'h500, 0);
        instr(1, 0, 32'h504, 0);
        idle(2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("rst_valid_now", req_valid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ready = 1'b1;
        instr(1, 1, 32'h600, 0);
        instr(1, 0, 32'h604, 0);
        idle(4);
        check("queue_drained", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
